// File: rtl/traffic_pkg.sv
// Shared definitions for the junction traffic-signal design: light encoding
// and default timing for the loop-detector conditioning.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int STUCK_CYCLES_DEF = 200;
    localparam int QMAX_DEF         = 15;

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for one raw loop input.
// 'deb' is the level the debouncer holds after this edge, so 'rise' lines up with the flip.
module loop_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic raw,
    output logic deb,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A mismatch seen for DEB_CYCLES consecutive samples flips the level.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb  = deb_d;
    assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/vehicle_detect.sv
// Qualifies the arrival/exit loops into the controller's car_present input,
// keeping a saturating waiting-vehicle count and a stuck arrival-loop fault.
module vehicle_detect
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF,
    parameter int QMAX         = QMAX_DEF,
    parameter int CNT_W        = $clog2(QMAX + 1)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             loop_arr_raw,
    input  logic             loop_exit_raw,
    output logic             car_present,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             fault
);

    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic             arr_deb;
    logic             arr_rise;
    logic             unused_exit_deb;
    logic             exit_rise;
    logic [CNT_W-1:0] queue_q;
    logic [CNT_W-1:0] queue_d;
    logic [SW-1:0]    stuck_q;
    logic [SW-1:0]    stuck_d;
    logic             fault_q;
    logic             fault_d;
    logic             car_q;
    logic             car_d;

    loop_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
        .clock   (clock),
        .clear_n (clear_n),
        .raw     (loop_arr_raw),
        .deb     (arr_deb),
        .rise    (arr_rise)
    );

    // Only the exit-loop rising edge matters; its level is not used.
    loop_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
        .clock   (clock),
        .clear_n (clear_n),
        .raw     (loop_exit_raw),
        .deb     (unused_exit_deb),
        .rise    (exit_rise)
    );

    always_comb begin
        queue_d = queue_q;
        if (arr_rise && !exit_rise && queue_q != CNT_W'(QMAX)) begin
            queue_d = queue_q + 1'b1;
        end else if (exit_rise && !arr_rise && queue_q != '0) begin
            queue_d = queue_q - 1'b1;
        end

        // Stuck timer counts edges since the debounced rise and saturates at the threshold.
        stuck_d = '0;
        if (arr_deb && !arr_rise) begin
            stuck_d = (stuck_q == SW'(STUCK_CYCLES)) ? stuck_q : stuck_q + 1'b1;
        end

        fault_d = arr_deb && (fault_q || stuck_d == SW'(STUCK_CYCLES));
        car_d   = (queue_d != '0) || fault_d;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            queue_q <= '0;
            stuck_q <= '0;
            fault_q <= 1'b0;
            car_q   <= 1'b0;
        end else begin
            queue_q <= queue_d;
            stuck_q <= stuck_d;
            fault_q <= fault_d;
            car_q   <= car_d;
        end
    end

    assign queue_cnt   = queue_q;
    assign fault       = fault_q;
    assign car_present = car_q;

endmodule

// File: tb/tb_vehicle_detect.sv
// Directed self-checking bench for vehicle_detect: table of loop pulses with
// expected count/car/fault, plus hand sequences for edge timing, saturation, stuck loop and reset.
module tb_vehicle_detect;

    logic       clock;
    logic       clear_n;
    logic       loop_arr_raw;
    logic       loop_exit_raw;
    logic       car_present;
    logic [3:0] queue_cnt;
    logic       fault;

    int checks;
    int passes;

    typedef struct {
        string      name;
        logic       arr;
        logic       ex;
        int         high;
        int         settle;
        logic [3:0] cnt;
        logic       car;
    } vec_t;

    vec_t vecs[10];

    vehicle_detect dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .loop_arr_raw  (loop_arr_raw),
        .loop_exit_raw (loop_exit_raw),
        .car_present   (car_present),
        .queue_cnt     (queue_cnt),
        .fault         (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Leaves the bench 1 time unit after the n-th following rising edge.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expCnt,
                               input logic expCar, input logic expFault);
        checks++;
        if (queue_cnt === expCnt) passes++;
        else $display("[TB] FAIL %s.queue_cnt: got %0d expected %0d", name, queue_cnt, expCnt);
        checks++;
        if (car_present === expCar) passes++;
        else $display("[TB] FAIL %s.car_present: got %b expected %b", name, car_present, expCar);
        checks++;
        if (fault === expFault) passes++;
        else $display("[TB] FAIL %s.fault: got %b expected %b", name, fault, expFault);
    endtask

    task automatic pulse(input logic a, input logic e, input int high, input int settle);
        loop_arr_raw  = a;
        loop_exit_raw = e;
        waitEdges(high);
        loop_arr_raw  = 1'b0;
        loop_exit_raw = 1'b0;
        waitEdges(settle);
    endtask

    task automatic applyStimulus(input vec_t v);
        pulse(v.arr, v.ex, v.high, v.settle);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        clear_n       = 1'b0;
        loop_arr_raw  = 1'b0;
        loop_exit_raw = 1'b0;

        vecs[0] = '{"glitch3_arr",   1'b1, 1'b0,  3, 12, 4'd0, 1'b0};
        vecs[1] = '{"arr10",         1'b1, 1'b0, 10, 12, 4'd1, 1'b1};
        vecs[2] = '{"exit10",        1'b0, 1'b1, 10, 12, 4'd0, 1'b0};
        vecs[3] = '{"spurious_exit", 1'b0, 1'b1, 10, 12, 4'd0, 1'b0};
        vecs[4] = '{"arr4_boundary", 1'b1, 1'b0,  4, 12, 4'd1, 1'b1};
        vecs[5] = '{"arr_b",         1'b1, 1'b0,  5, 12, 4'd2, 1'b1};
        vecs[6] = '{"arr_c",         1'b1, 1'b0,  5, 12, 4'd3, 1'b1};
        vecs[7] = '{"simultaneous",  1'b1, 1'b1, 10, 12, 4'd3, 1'b1};
        vecs[8] = '{"glitch3_exit",  1'b0, 1'b1,  3, 12, 4'd3, 1'b1};
        vecs[9] = '{"exit_a",        1'b0, 1'b1,  5, 12, 4'd2, 1'b1};

        // Reset held while both loops toggle.
        waitEdges(1);
        for (int i = 0; i < 6; i++) begin
            loop_arr_raw  = ~loop_arr_raw;
            loop_exit_raw = (i % 3) == 0;
            waitEdges(1);
            checkOutput("in_reset", 4'd0, 1'b0, 1'b0);
        end
        loop_arr_raw  = 1'b0;
        loop_exit_raw = 1'b0;
        waitEdges(2);
        clear_n = 1'b1;
        waitEdges(10);
        checkOutput("after_release", 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].cnt, vecs[i].car, 1'b0);
        end

        // Arrival is counted exactly on edge 6, not before.
        loop_arr_raw = 1'b1;
        waitEdges(5);
        checkOutput("arr_edge5", 4'd2, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("arr_edge6", 4'd3, 1'b1, 1'b0);
        waitEdges(10);
        checkOutput("arr_held", 4'd3, 1'b1, 1'b0);
        loop_arr_raw = 1'b0;
        waitEdges(12);

        pulse(1'b0, 1'b1, 5, 12);
        pulse(1'b0, 1'b1, 5, 12);
        checkOutput("drain_to_1", 4'd1, 1'b1, 1'b0);
        loop_exit_raw = 1'b1;
        waitEdges(5);
        checkOutput("exit_edge5", 4'd1, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("exit_edge6", 4'd0, 1'b0, 1'b0);
        loop_exit_raw = 1'b0;
        waitEdges(12);

        // Saturation at 15 and no underflow below 0.
        for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0, 5, 10);
        checkOutput("sat_15", 4'd15, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 5, 10);
        checkOutput("sat_minus1", 4'd14, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) pulse(1'b0, 1'b1, 5, 10);
        checkOutput("drain_0", 4'd0, 1'b0, 1'b0);

        // Stuck arrival loop held 250 cycles.
        loop_arr_raw = 1'b1;
        waitEdges(205);
        checkOutput("stuck_205", 4'd1, 1'b1, 1'b0);
        waitEdges(1);
        checkOutput("stuck_206", 4'd1, 1'b1, 1'b1);
        waitEdges(44);
        loop_arr_raw = 1'b0;
        waitEdges(5);
        checkOutput("stuck_fall5", 4'd1, 1'b1, 1'b1);
        waitEdges(1);
        checkOutput("stuck_fall6", 4'd1, 1'b1, 1'b0);
        waitEdges(6);
        pulse(1'b0, 1'b1, 5, 12);
        checkOutput("stuck_cleanup", 4'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a valid arrival debounce.
        pulse(1'b1, 1'b0, 5, 12);
        pulse(1'b1, 1'b0, 5, 12);
        checkOutput("pre_reset", 4'd2, 1'b1, 1'b0);
        loop_arr_raw = 1'b1;
        waitEdges(3);
        clear_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0, 1'b0);
        loop_arr_raw = 1'b0;
        waitEdges(2);
        clear_n = 1'b1;
        waitEdges(12);
        checkOutput("post_reset", 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
